// File: rtl/fifo_dual_port_if.sv
// -----------------------------------------------------------------------------
// fifo_dual_port_if
//   Bundles the push/pop handshake, data and status signals of fifo_dual_port.
//   Handshake semantics: a push is taken on a rising clk edge when
//   push & (~full | pop); a pop is taken when pop & ~empty, and the popped
//   word is presented on data_out with valid_out high for exactly one cycle
//   after that edge. There is no back-pressure beyond the status flags.
//
//   Modports:
//     master - producer/consumer side (drives push, data_in, pop)
//     slave  - FIFO side (drives data_out, valid_out, flags, count, error)
// -----------------------------------------------------------------------------
interface fifo_dual_port_if #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 3
);
    logic                  push;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  error;

    modport master (
        output push, data_in, pop,
        input  data_out, valid_out, full, empty, almost_full, almost_empty,
               count, error
    );

    modport slave (
        input  push, data_in, pop,
        output data_out, valid_out, full, empty, almost_full, almost_empty,
               count, error
    );
endinterface

// File: rtl/fifo_dual_port.sv
// -----------------------------------------------------------------------------
// fifo_dual_port
//   8 x 12-bit synchronous FIFO built around an internal dual-port memory
//   (port A write-only from push, port B read-only from pop). Tracks occupancy
//   and derives status flags combinationally from the registered count.
//
//   Ports:
//     clk    - system clock, rising edge
//     reset  - synchronous, active-high; wins over push/pop in the same cycle
//     bus    - fifo_dual_port_if.slave: push, data_in, pop, data_out (registered),
//              valid_out, full, empty, almost_full, almost_empty, count, error
//
//   Build option:
//     FIFO_ERROR_FLAG_EN - when defined, error is a sticky overflow/underflow
//                          flag cleared only by reset; otherwise error is 0.
// -----------------------------------------------------------------------------
module fifo_dual_port #(
    parameter int DATA_WIDTH   = 12,
    parameter int ADDR_WIDTH   = 3,
    parameter int ALMOST_FULL  = 6,
    parameter int ALMOST_EMPTY = 2
) (
    input  logic               clk,
    input  logic               reset,
    fifo_dual_port_if.slave    bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;

    logic full_w, empty_w;
    logic push_acc, pop_acc;

    assign full_w  = (count_q == CNT_W'(DEPTH));
    assign empty_w = (count_q == '0);

    // A pop on a full FIFO frees a slot in the same edge, so push may proceed.
    assign push_acc = bus.push & (~full_w | bus.pop);
    assign pop_acc  = bus.pop & ~empty_w;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;

        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (pop_acc) begin
            rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(1);
            data_out_d  = mem_q[rd_ptr_q];
            valid_out_d = 1'b1;
        end

        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    // Storage is intentionally not reset; stale words are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (!reset && push_acc) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

`ifdef FIFO_ERROR_FLAG_EN
    logic error_q, error_d;
    logic overflow, underflow;

    assign overflow  = bus.push & full_w & ~bus.pop;
    // Any pop seen while empty is ignored, including one paired with a push.
    assign underflow = bus.pop & empty_w;

    always_comb begin
        error_d = error_q | overflow | underflow;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign bus.error = error_q;
`else
    assign bus.error = 1'b0;
`endif

    assign bus.data_out     = data_out_q;
    assign bus.valid_out    = valid_out_q;
    assign bus.count        = count_q;
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (count_q >= CNT_W'(ALMOST_FULL));
    assign bus.almost_empty = (count_q <= CNT_W'(ALMOST_EMPTY));
endmodule
